game_sequencer: RTL and testbench

Frame-level game controller for the ScreamRun display pipeline. It sits between the VGA timing generator and the pixel mux, and owns these outputs: the background scroll offset added to the display column, the scroll speed, the run score and the game state. It detects character/encounter overlap from the per-pixel visibility flags and sequences IDLE → RUN → HIT → OVER. All outputs are registered.

---
 rtl/game_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frame-level ScreamRun game controller: scroll, speed, score and IDLE/RUN/HIT/OVER sequencing.
// Optional macro SCORE_BCD_EN selects a packed-BCD score saturating at 9999.
module game_sequencer #(
    parameter int unsigned SCROLL_W          = 32,
    parameter int unsigned SPEED_INIT        = 3,
    parameter int unsigned SPEED_MAX         = 8,
    parameter int unsigned SPEED_STEP_FRAMES = 600,
    parameter int unsigned HIT_FRAMES        = 60
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [11:0]         display_col,
    input  logic [10:0]         display_row,
    input  logic                visible,
    input  logic                char_visible,
    input  logic                enc1_visible,
    output logic [SCROLL_W-1:0] scroll_offset,
    output logic [3:0]          speed,
    output logic [15:0]         score,
    output logic [1:0]          state,
    output logic                run_en,
    output logic                game_over,
    output logic                frame_tick
);

    localparam int unsigned FCNT_W = $clog2(SPEED_STEP_FRAMES);
    localparam int unsigned HCNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HIT  = 2'b10;
    localparam logic [1:0] ST_OVER = 2'b11;

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SPEED_STEP_FRAMES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HIT_FRAMES - 1);
    localparam logic [3:0]        SPEED_RST = 4'(SPEED_INIT);
    localparam logic [3:0]        SPEED_TOP = 4'(SPEED_MAX);
`ifdef SCORE_BCD_EN
    localparam logic [15:0]       SCORE_SAT = 16'h9999;
`else
    localparam logic [15:0]       SCORE_SAT = 16'hFFFF;
`endif

    logic                start_q;
    logic                hit_pending;
    logic [FCNT_W-1:0]   frame_cnt;
    logic [HCNT_W-1:0]   hit_cnt;

    logic                frame_evt;
    logic                start_rise;
    logic                overlap;
    logic [1:0]          state_nxt;
    logic [SCROLL_W-1:0] scroll_nxt;
    logic [3:0]          speed_nxt;
    logic [15:0]         score_nxt;
    logic                hit_pending_nxt;
    logic [FCNT_W-1:0]   frame_cnt_nxt;
    logic [HCNT_W-1:0]   hit_cnt_nxt;

    // One-step score increment; BCD variant ripples a decimal carry across the four digits.
    function automatic logic [15:0] score_inc(input logic [15:0] value);
`ifdef SCORE_BCD_EN
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (result[d*4 +: 4] == 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = result[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
`else
        return value + 16'd1;
`endif
    endfunction

    assign frame_evt  = (display_col == 12'd0) && (display_row == 11'd0);
    assign start_rise = start && !start_q;
    assign overlap    = visible && char_visible && enc1_visible;

    // Next-state and next-value decode.
    always_comb begin
        state_nxt       = state;
        scroll_nxt      = scroll_offset;
        speed_nxt       = speed;
        score_nxt       = score;
        hit_pending_nxt = hit_pending;
        frame_cnt_nxt   = frame_cnt;
        hit_cnt_nxt     = hit_cnt;

        case (state)
            ST_IDLE: begin
                scroll_nxt      = '0;
                score_nxt       = '0;
                speed_nxt       = SPEED_RST;
                frame_cnt_nxt   = '0;
                hit_pending_nxt = 1'b0;
                if (start_rise) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_evt && hit_pending) begin
                    state_nxt       = ST_HIT;
                    hit_cnt_nxt     = HCNT_LOAD;
                    hit_pending_nxt = 1'b0;
                end else begin
                    if (frame_evt) begin
                        scroll_nxt = scroll_offset + SCROLL_W'(speed);
                        if (score != SCORE_SAT) begin
                            score_nxt = score_inc(score);
                        end
                        if (frame_cnt == FCNT_LAST) begin
                            frame_cnt_nxt = '0;
                            if (speed < SPEED_TOP) begin
                                speed_nxt = speed + 4'd1;
                            end
                        end else begin
                            frame_cnt_nxt = frame_cnt + FCNT_W'(1);
                        end
                    end
                    // An overlap on the FE pixel itself is held for the following frame.
                    if (overlap) begin
                        hit_pending_nxt = 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (frame_evt) begin
                    if (hit_cnt == '0) begin
                        state_nxt = ST_OVER;
                    end else begin
                        hit_cnt_nxt = hit_cnt - HCNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_nxt     = ST_IDLE;
                    scroll_nxt    = '0;
                    score_nxt     = '0;
                    speed_nxt     = SPEED_RST;
                    frame_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; run_en/game_over decode the next state so they align with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            scroll_offset <= '0;
            speed         <= SPEED_RST;
            score         <= '0;
            run_en        <= 1'b0;
            game_over     <= 1'b0;
            frame_tick    <= 1'b0;
            start_q       <= 1'b0;
            hit_pending   <= 1'b0;
            frame_cnt     <= '0;
            hit_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            scroll_offset <= scroll_nxt;
            speed         <= speed_nxt;
            score         <= score_nxt;
            run_en        <= (state_nxt == ST_RUN);
            game_over     <= (state_nxt == ST_OVER);
            frame_tick    <= frame_evt;
            start_q       <= start;
            hit_pending   <= hit_pending_nxt;
            frame_cnt     <= frame_cnt_nxt;
            hit_cnt       <= hit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: random and directed frames against a frame-count reference model.
module tb_game_sequencer;

    localparam int unsigned SCROLL_W   = 8;
    localparam int unsigned SPEED_INIT = 3;
    localparam int unsigned SPEED_MAX  = 8;
    localparam int unsigned STEP       = 4;
    localparam int unsigned HIT_FRAMES = 5;
    localparam int unsigned EXP_W      = 2 + SCROLL_W + 4 + 16 + 3;
`ifdef SCORE_BCD_EN
    localparam int          SCORE_CAP  = 9999;
    localparam logic [15:0] CAP_SCORE  = 16'h9999;
    localparam logic [15:0] TEN_SCORE  = 16'h0010;
`else
    localparam int          SCORE_CAP  = 65535;
    localparam logic [15:0] CAP_SCORE  = 16'hFFFF;
    localparam logic [15:0] TEN_SCORE  = 16'h000A;
`endif
    localparam logic [EXP_W-1:0] RESET_VEC = {2'b00, SCROLL_W'(0), 4'd3, 16'h0000, 3'b000};

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [11:0]         display_col = 12'd0;
    logic [10:0]         display_row = 11'd0;
    logic                visible = 1'b0;
    logic                char_visible = 1'b0;
    logic                enc1_visible = 1'b0;
    logic [SCROLL_W-1:0] scroll_offset;
    logic [3:0]          speed;
    logic [15:0]         score;
    logic [1:0]          state;
    logic                run_en;
    logic                game_over;
    logic                frame_tick;
    logic [EXP_W-1:0]    dut_vec;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: game state plus count of RUN frames survived; speed and score derive from that count.
    int m_state, m_n, m_scroll, m_hitfe;
    bit m_pend, m_startq, m_tick;

    game_sequencer #(
        .SCROLL_W(SCROLL_W), .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX),
        .SPEED_STEP_FRAMES(STEP), .HIT_FRAMES(HIT_FRAMES)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .display_col(display_col), .display_row(display_row), .visible(visible),
        .char_visible(char_visible), .enc1_visible(enc1_visible),
        .scroll_offset(scroll_offset), .speed(speed), .score(score), .state(state),
        .run_en(run_en), .game_over(game_over), .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    assign dut_vec = {state, scroll_offset, speed, score, run_en, game_over, frame_tick};

    function automatic int m_speed();
        int s;
        s = SPEED_INIT + m_n / STEP;
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction

    function automatic logic [15:0] m_score();
        int k;
        k = (m_n > SCORE_CAP) ? SCORE_CAP : m_n;
`ifdef SCORE_BCD_EN
        return {4'(k / 1000), 4'((k / 100) % 10), 4'((k / 10) % 10), 4'(k % 10)};
`else
        return 16'(k);
`endif
    endfunction

    function automatic logic [EXP_W-1:0] m_expect();
        return {2'(m_state), SCROLL_W'(m_scroll), 4'(m_speed()), m_score(),
                (m_state == 1), (m_state == 3), m_tick};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_n = 0; m_scroll = 0; m_hitfe = 0;
        m_pend = 0; m_startq = 0; m_tick = 0;
    endfunction

    function automatic void model_clock(logic [11:0] c, logic [10:0] r, logic v, logic ch, logic en, logic st);
        bit fe, rise, ov;
        fe   = (c == 0) && (r == 0);
        rise = st && !m_startq;
        ov   = v && ch && en;
        case (m_state)
            0: if (rise) m_state = 1;
            1: begin
                if (fe && m_pend) begin
                    m_state = 2; m_pend = 0; m_hitfe = 0;
                end else begin
                    if (fe) begin
                        m_scroll = (m_scroll + m_speed()) % (1 << SCROLL_W);
                        m_n++;
                    end
                    if (ov) m_pend = 1;
                end
            end
            2: if (fe) begin
                m_hitfe++;
                if (m_hitfe == HIT_FRAMES) m_state = 3;
            end
            default: if (rise) begin
                m_state = 0; m_n = 0; m_scroll = 0;
            end
        endcase
        m_startq = st;
        m_tick   = fe;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, return at the falling edge.
    task automatic step(input logic [11:0] c, input logic [10:0] r, input logic v,
                        input logic ch, input logic en, input logic st);
        display_col = c; display_row = r; visible = v;
        char_visible = ch; enc1_visible = en; start = st;
        @(posedge clock);
        if (reset) model_reset();
        else model_clock(c, r, v, ch, en, st);
        @(negedge clock);
    endtask

    task automatic frame(input int len, input int ov_at, input logic st);
        for (int i = 0; i < len; i++)
            step(12'(i), 11'd0, 1'b1, 1'(ov_at == i), 1'(ov_at == i), st);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(12'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(12'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (dut_vec !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
        end
        reset = 1'b0;
        step(12'd3, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle_hold: state got %b want 00", state);
        end
    endtask

    task automatic test_basic_run();
        int ticks, wide;
        logic prev;
        ticks = 0; wide = 0; prev = 1'b0;
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(12'd6, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (state !== 2'b01 || run_en !== 1'b1 || scroll_offset !== 8'd0) begin
            miscompares++;
            $display("FAIL start_to_run: state %b run_en %b scroll %0d want 01 1 0", state, run_en, scroll_offset);
        end
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++) begin
                step(12'(i), 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                ticks += int'(frame_tick);
                if (frame_tick && prev) wide++;
                prev = frame_tick;
            end
        vectors++;
        if (state !== 2'b01 || scroll_offset !== 8'd9 || score !== 16'd3 || speed !== 4'd3) begin
            miscompares++;
            $display("FAIL three_frames: state %b scroll %0d score %0d speed %0d want 01 9 3 3",
                     state, scroll_offset, score, speed);
        end
        vectors++;
        if (ticks != 3 || wide != 0) begin
            miscompares++;
            $display("FAIL frame_tick_pulses: ticks %0d wide %0d want 3 0", ticks, wide);
        end
    endtask

    task automatic test_speed_ramp();
        while (m_n < 600) begin
            frame(int'($urandom_range(2, 4)), -1, 1'b0);
            vectors++;
            if (dut_vec !== m_expect()) begin
                miscompares++;
                $display("FAIL ramp_frame%0d: got %h want %h", m_n, dut_vec, m_expect());
            end
            if (m_n == 4 || m_n == 8 || m_n == 600) begin
                vectors++;
                if (speed !== ((m_n == 4) ? 4'd4 : (m_n == 8) ? 4'd5 : 4'd8)) begin
                    miscompares++;
                    $display("FAIL ramp_speed_at_%0d: got %0d", m_n, speed);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [SCROLL_W-1:0] s0;
        s0 = scroll_offset;
        for (int f = 0; f < 40; f++) frame(2, -1, 1'b0);
        vectors++;
        if (scroll_offset !== SCROLL_W'((int'(s0) + 8 * 40) % 256)) begin
            miscompares++;
            $display("FAIL scroll_wrap: got %0d want %0d", scroll_offset, (int'(s0) + 320) % 256);
        end
    endtask

    task automatic test_hit();
        logic [SCROLL_W-1:0] s_hit;
        logic [15:0]         sc_hit;
        frame(4, 2, 1'b0);
        s_hit = scroll_offset;
        sc_hit = score;
        vectors++;
        if (state !== 2'b01 || dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL overlap_frame: got %h want %h", dut_vec, m_expect());
        end
        frame(4, -1, 1'b0);
        vectors++;
        if (state !== 2'b10 || scroll_offset !== s_hit || score !== sc_hit || run_en !== 1'b0) begin
            miscompares++;
            $display("FAIL enter_hit: state %b scroll %0d score %0d want 10 %0d %0d",
                     state, scroll_offset, score, s_hit, sc_hit);
        end
        for (int f = 0; f < int'(HIT_FRAMES) - 1; f++) frame(3, int'($urandom_range(0, 2)), 1'b0);
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL hit_hold: state got %b want 10", state);
        end
        frame(3, -1, 1'b0);
        vectors++;
        if (state !== 2'b11 || game_over !== 1'b1 || score !== sc_hit || scroll_offset !== s_hit) begin
            miscompares++;
            $display("FAIL enter_over: state %b game_over %b score %0d want 11 1 %0d", state, game_over, score, sc_hit);
        end
    endtask

    task automatic test_start_control();
        reset = 1'b1;
        step(12'd2, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        // start_q clears in reset, so a level held through release reads as a press.
        frame(4, -1, 1'b1);
        frame(4, -1, 1'b1);
        vectors++;
        if (dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL start_held_over_reset: got %h want %h", dut_vec, m_expect());
        end
        frame(4, -1, 1'b0);
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(4, -1, 1'b0);
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("FAIL release_press_run: state got %b want 01", state);
        end
        frame(4, -1, 1'b1);
        vectors++;
        if (state !== 2'b01 || dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL press_in_run: got %h want %h", dut_vec, m_expect());
        end
        frame(4, 0, 1'b0);
        vectors++;
        if (state !== 2'b01 || dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL overlap_on_fe_pixel: got %h want %h", dut_vec, m_expect());
        end
        frame(4, -1, 1'b1);
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL fe_overlap_next_hit: state got %b want 10", state);
        end
        for (int f = 0; f < int'(HIT_FRAMES); f++) frame(3, -1, 1'b0);
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (dut_vec !== RESET_VEC) begin
            miscompares++;
            $display("FAIL press_in_over: got %h want %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_reset_mid();
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(4, -1, 1'b0);
        frame(4, -1, 1'b0);
        step(12'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(12'd1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset_mid_frame: got %h want %h", dut_vec, RESET_VEC);
        end
        step(12'd2, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        frame(4, -1, 1'b0);
        vectors++;
        if (dut_vec !== m_expect() || state !== 2'b00) begin
            miscompares++;
            $display("FAIL resume_after_reset: got %h want %h", dut_vec, m_expect());
        end
    endtask

    task automatic test_random();
        logic st;
        st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) st = ~st;
            step(12'($urandom_range(0, 3)), 11'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), st);
            vectors++;
            if (dut_vec !== m_expect()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, m_expect());
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #2;
                model_reset();
                vectors++;
                if (dut_vec !== RESET_VEC) begin
                    miscompares++;
                    $display("FAIL random_reset%0d: got %h want %h", i, dut_vec, RESET_VEC);
                end
                step(12'd1, 11'd1, 1'b0, 1'b0, 1'b0, st);
                reset = 1'b0;
            end
        end
    endtask

    task automatic test_score_sat();
        reset = 1'b1;
        step(12'd1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(12'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL score_nine: got %h want %h", dut_vec, m_expect());
        end
        step(12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (score !== TEN_SCORE) begin
            miscompares++;
            $display("FAIL score_ten: got %h want %h", score, TEN_SCORE);
        end
        for (int i = 0; i < SCORE_CAP - 5; i++) step(12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (score !== CAP_SCORE || dut_vec !== m_expect()) begin
            miscompares++;
            $display("FAIL score_saturate: got %h want %h (score %h want %h)", dut_vec, m_expect(), score, CAP_SCORE);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_run();
        test_speed_ramp();
        test_wrap();
        test_hit();
        test_start_control();
        test_reset_mid();
        test_random();
        test_score_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
